// File: rtl/pwm_spi_pkg.sv
// Shared types and constants for the SPI command sequencer and its peers.
package pwm_spi_pkg;

  // Address width of the register file port.
  localparam int ADDR_W = 6;

  // Command byte bit that selects write (1) versus read (0).
  localparam int CMD_WR_BIT = 7;

  // Default constant upper nibble of the status byte.
  localparam logic [3:0] STATUS_ID_DEFAULT = 4'hA;

  // Sequencer states: waiting for a command, streaming writes, streaming reads.
  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Bus between the SPI byte bridge / register file and the command sequencer.
//
// Handshake: byte_sync is a one-cycle pulse qualifying data_in; there is no
// back-pressure. data_out is level-held and sampled by the bridge at each
// byte boundary. reg_we / reg_re are one-cycle strobes qualifying reg_addr
// (and reg_wdata for writes); reg_rdata is valid the cycle after reg_re.
interface spi_cmd_ctrl_if;
  import pwm_spi_pkg::*;

  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  // Sequencer side.
  modport master (
    input  byte_sync, data_in, reg_rdata,
    output data_out, reg_addr, reg_wdata, reg_we, reg_re
  );

  // Bridge / register-file side.
  modport slave (
    output byte_sync, data_in, reg_rdata,
    input  data_out, reg_addr, reg_wdata, reg_we, reg_re
  );

endinterface

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI byte bridge and the PWM register file.
// First byte of a frame is the command (bit7 write/read, bits[5:0] address);
// following bytes are write data or read slots. Read data is pre-fetched onto
// data_out so it is ready at the next byte boundary.
// Build option: SPI_CMD_AUTOINC_EN enables burst address auto-increment.
module spi_cmd_ctrl
  import pwm_spi_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [3:0] STATUS_ID = STATUS_ID_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs_n,
  spi_cmd_ctrl_if.master  bus,
  output logic            err,
  output state_t          dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;       // running frame address
  logic [ADDR_W-1:0] addr_q, addr_d;     // address presented to the reg file
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              oor_q, oor_d;       // read slot targeting a missing register
  logic              cap_q, cap_d;       // capture read result this cycle
  logic              cap_oor_q, cap_oor_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;   // cs_n seen high since reset
  logic [7:0]        data_out_q, data_out_d;

  logic              accept;
  logic [ADDR_W-1:0] nxt_addr;

  // Address step between data bytes: saturating increment or hold.
  function automatic logic [ADDR_W-1:0] addr_adv(input logic [ADDR_W-1:0] a);
`ifdef SPI_CMD_AUTOINC_EN
    return (a == {ADDR_W{1'b1}}) ? a : a + 6'd1;
`else
    return a;
`endif
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // A byte counts only inside a frame that began after the last reset.
  assign accept = bus.byte_sync && !cs_n && armed_q;

  // Next-state, strobe and data_out computation.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    oor_d      = 1'b0;
    cap_d      = (re_q || oor_q) && !cs_n;
    cap_oor_d  = oor_q;
    err_d      = err_q;
    armed_d    = armed_q | cs_n;
    data_out_d = data_out_q;
    nxt_addr   = addr_adv(cur_q);

    if (cs_n) begin
      state_d = S_CMD;
    end else if (accept) begin
      unique case (state_q)
        S_CMD: begin
          // Status has already been shifted out at this boundary.
          err_d = 1'b0;
          cur_d = bus.data_in[ADDR_W-1:0];
          if (bus.data_in[CMD_WR_BIT]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
            addr_d  = bus.data_in[ADDR_W-1:0];
            if (addr_ok(bus.data_in[ADDR_W-1:0])) begin
              re_d = 1'b1;
            end else begin
              oor_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
        S_WR: begin
          addr_d  = cur_q;
          wdata_d = bus.data_in;
          if (addr_ok(cur_q)) we_d = 1'b1;
          else                err_d = 1'b1;
          cur_d = nxt_addr;
        end
        S_RD: begin
          cur_d  = nxt_addr;
          addr_d = nxt_addr;
          if (addr_ok(nxt_addr)) begin
            re_d = 1'b1;
          end else begin
            oor_d = 1'b1;
            err_d = 1'b1;
          end
        end
        default: state_d = S_CMD;
      endcase
    end

    if (state_d == S_CMD) begin
      data_out_d = {STATUS_ID, 3'b000, err_d};
    end else if (cap_q) begin
      data_out_d = cap_oor_q ? 8'h00 : bus.reg_rdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      cur_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      oor_q      <= 1'b0;
      cap_q      <= 1'b0;
      cap_oor_q  <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      data_out_q <= {STATUS_ID, 4'b0000};
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      oor_q      <= oor_d;
      cap_q      <= cap_d;
      cap_oor_q  <= cap_oor_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: bridge driver, register-file model,
// strobe monitor and write scoreboard.
module tb_spi_cmd_ctrl;
  import pwm_spi_pkg::*;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   cs_n = 1'b1;
  logic   err;
  state_t dbg_state;

  spi_cmd_ctrl_if bus ();

  spi_cmd_ctrl #(.NUM_REGS(16), .STATUS_ID(4'hA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .bus       (bus.master),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
  end

  // ---------------- monitor ----------------
  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];
  logic [5:0]  rd_log[$];
  logic [7:0]  miso[$];
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (bus.reg_we) obs_q.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) rd_log.push_back(bus.reg_addr);
    if (bus.reg_we && bus.reg_re) both_cnt++;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_wr_entry"}, 32'(obs_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'h0A0);
    check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'h0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'h0);
    check({tag, "_reg_we"}, 32'(bus.reg_we), 32'h0);
    check({tag, "_reg_re"}, 32'(bus.reg_re), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_CMD));
  endtask

  // ---------------- driver ----------------
  logic       snap_we, snap_re;
  logic [5:0] snap_addr;
  logic [7:0] snap_wdata;

  task automatic start_frame();
    @(posedge clk); #1;
    cs_n = 1'b0;
    miso.delete();
    obs_q.delete();
    rd_log.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic end_frame();
    repeat (2) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One byte period of 6 clocks; the bridge loads data_out at the boundary.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.data_in   = b;
    bus.byte_sync = 1'b1;
    @(negedge clk);
    miso.push_back(bus.data_out);
    @(posedge clk); #1;
    bus.byte_sync = 1'b0;
    @(negedge clk);
    snap_we    = bus.reg_we;
    snap_re    = bus.reg_re;
    snap_addr  = bus.reg_addr;
    snap_wdata = bus.reg_wdata;
    repeat (4) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n5;
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    bus.reg_rdata = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h80;
    mem[5] = 8'hC3;
    mem[6] = 8'h3C;

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single write: 83 5A
    start_frame();
    send_byte(8'h83);
    send_byte(8'h5A);
    check("wr_lat_we", 32'(snap_we), 32'h1);
    check("wr_lat_addr", 32'(snap_addr), 32'h3);
    check("wr_lat_wdata", 32'(snap_wdata), 32'h5A);
    end_frame();
    exp_q.push_back({6'd3, 8'h5A});
    check_writes("wr1");
    check("wr1_err", 32'(err), 32'h0);
    check("wr1_no_read", 32'(rd_log.size()), 32'h0);

    // Read frame: 05 00 00
    start_frame();
    send_byte(8'h05);
    check("rd_lat_re", 32'(snap_re), 32'h1);
    check("rd_lat_addr", 32'(snap_addr), 32'h5);
    send_byte(8'h00);
    send_byte(8'h00);
    end_frame();
    check("rd_status", 32'(miso[0]), 32'hA0);
    check("rd_data_a", 32'(miso[1]), 32'hC3);
    check("rd_data_a1", 32'(miso[2]), AUTOINC ? 32'h3C : 32'hC3);
    n5 = 0;
    foreach (rd_log[i]) if (rd_log[i] == 6'd5) n5++;
    check("rd_count_addr5", 32'(n5), AUTOINC ? 32'd1 : 32'd3);
    check("rd_count_total", 32'(rd_log.size()), 32'd3);
    check("rd_no_write", 32'(obs_q.size()), 32'h0);

    // Burst write past the end: 8E 11 22 33
    start_frame();
    send_byte(8'h8E);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_frame();
    if (AUTOINC) begin
      exp_q.push_back({6'd14, 8'h11});
      exp_q.push_back({6'd15, 8'h22});
    end else begin
      exp_q.push_back({6'd14, 8'h11});
      exp_q.push_back({6'd14, 8'h22});
      exp_q.push_back({6'd14, 8'h33});
    end
    check_writes("burst");
    check("burst_err", 32'(err), AUTOINC ? 32'h1 : 32'h0);

    // Next frame reports status, then clears err
    start_frame();
    send_byte(8'h01);
    send_byte(8'h00);
    end_frame();
    check("post_burst_status", 32'(miso[0]), AUTOINC ? 32'hA1 : 32'hA0);
    check("post_burst_err_clr", 32'(err), 32'h0);

    // Read of highest address (out of range)
    start_frame();
    send_byte(8'h3F);
    send_byte(8'h00);
    send_byte(8'h00);
    end_frame();
    check("oor_rd_data1", 32'(miso[1]), 32'h00);
    check("oor_rd_data2", 32'(miso[2]), 32'h00);
    check("oor_no_re", 32'(rd_log.size()), 32'h0);
    check("oor_err", 32'(err), 32'h1);

    // Frame aborted after command 85, before data
    start_frame();
    send_byte(8'h85);
    end_frame();
    check("abort_status", 32'(miso[0]), 32'hA1);
    check("abort_no_we", 32'(obs_q.size()), 32'h0);
    check("abort_state", 32'(dbg_state), 32'(S_CMD));
    check("abort_err_clr", 32'(err), 32'h0);

    // Next frame decodes from its first byte
    start_frame();
    send_byte(8'h83);
    send_byte(8'h77);
    end_frame();
    check("after_abort_status", 32'(miso[0]), 32'hA0);
    exp_q.push_back({6'd3, 8'h77});
    check_writes("after_abort");

    // Reset mid-burst
    start_frame();
    send_byte(8'h8F);
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_rst_err", 32'(err), AUTOINC ? 32'h1 : 32'h0);
    #3 rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete();
    rd_log.delete();
    send_byte(8'h44);
    send_byte(8'h55);
    check("rst_no_we", 32'(obs_q.size()), 32'h0);
    check("rst_no_re", 32'(rd_log.size()), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_CMD));
    end_frame();

    // Fresh frame after cs_n toggle
    start_frame();
    send_byte(8'h82);
    send_byte(8'h99);
    end_frame();
    check("post_rst_status", 32'(miso[0]), 32'hA0);
    exp_q.push_back({6'd2, 8'h99});
    check_writes("post_rst");

    check("we_re_exclusive", 32'(both_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
